// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types and constants for the multi-cycle divide sequencer.
package div_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int DIV_ITER = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;
endpackage

// File: rtl/div_ctrl_step.sv
// div_step: one combinational radix-2 restoring divide iteration.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] trial;
    // A negative trial means the shifted remainder was below the divisor, so its top bit was 0.
    assign trial = {rem_i, quo_i[WIDTH-1]} - {1'b0, div_i};
    assign rem_o = trial[WIDTH] ? {rem_i[WIDTH-2:0], quo_i[WIDTH-1]} : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: DIV/DIVU sequencer for EX; stalls the pipeline and returns {remainder, quotient}.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_ITER,
    parameter int ITER  = DIV_ITER
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o,
    output logic               busy_o
);
    localparam int CW = $clog2(ITER);
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, rem_n, quo_n, a_abs, b_abs;
    logic               sq_q, sq_d, sr_q, sr_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i(rem_q), .quo_i(quo_q), .div_i(dvs_q), .rem_o(rem_n), .quo_o(quo_n)
    );

    assign a_abs    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign ready_o  = state_q == DONE;
    assign busy_o   = state_q != IDLE;
    assign stall_o  = start_i & ~ready_o & ~annul_i;
    assign result_o = res_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: if (start_i && !annul_i) begin
                rem_d   = '0;
                quo_d   = a_abs;
                dvs_d   = b_abs;
                cnt_d   = '0;
                sq_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                sr_d    = signed_i & a_i[WIDTH-1];
                state_d = (b_i == '0) ? DONE : CALC;
                if (b_i == '0) res_d = {a_i, DIV0_QUOT};
            end
            // A dropped start_i means an outer flush squashed the instruction.
            CALC: if (annul_i || !start_i) begin
                state_d = IDLE;
            end else begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d                = DONE;
                    res_d[HI_MSB:HI_LSB]   = sr_q ? -rem_n : rem_n;
                    res_d[LO_MSB:LO_LSB]   = sq_q ? -quo_n : quo_n;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed checks of div_ctrl against an arithmetic reference model.
module tb_div_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o, stall_o, busy_o;
    int          tests = 0;
    int          fails = 0;

    div_ctrl dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
        .a_i(a_i), .b_i(b_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        ma = (s && a[31]) ? 32'(0 - a) : a;
        mb = (s && b[31]) ? 32'(0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (s && (a[31] != b[31])) q = 32'(0 - q);
        if (s && a[31]) r = 32'(0 - r);
        return {r, q};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] exp;
        int          lat, stalls;
        bit          done;
        exp = model(a, b, s);
        @(negedge clk);
        start_i = 1'b1; signed_i = s; a_i = a; b_i = b;
        lat = -1; stalls = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall_o) stalls++;
            if (ready_o) begin
                done = 1;
                lat  = c;
            end else begin
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    a_i = $urandom; b_i = $urandom; signed_i = 1'($urandom);
                end
            end
        end
        check("ready_seen", 64'(done), 64'd1);
        check("latency", 64'(lat), (b == 0) ? 64'd1 : 64'd33);
        check("stall_cycles", 64'(stalls), (b == 0) ? 64'd1 : 64'd33);
        check("result", result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("idle_after_done", {62'd0, busy_o, ready_o}, 64'd0);
        check("result_held", result_o, exp);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; a_i = a; b_i = b;
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] ra, rb;
        #1;
        check("reset_result", result_o, 64'd0);
        check("reset_flags", {61'd0, busy_o, ready_o, stall_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_div(32'd7, 32'd2, 1'b0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div(32'h1234_5678, 32'd0, 1'b0);
        run_div(32'h8000_0000, 32'd0, 1'b1);

        // annul mid-CALC
        prev = result_o;
        start_op(32'd100, 32'd3);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        #1 check("annul_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        #1;
        check("annul_idle", {62'd0, busy_o, ready_o}, 64'd0);
        check("annul_result", result_o, prev);
        @(negedge clk);
        run_div(32'd9, 32'd3, 1'b0);

        // start dropped mid-CALC
        prev = result_o;
        start_op(32'd50, 32'd7);
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check("squash_idle", {62'd0, busy_o, ready_o}, 64'd0);
        check("squash_result", result_o, prev);

        // start with annul in IDLE is ignored
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; a_i = 32'd5; b_i = 32'd0;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        #1 check("annul_ignore", {62'd0, busy_o, ready_o}, 64'd0);

        // async reset mid-CALC
        start_op(32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rst_result", result_o, 64'd0);
        check("rst_flags", {62'd0, busy_o, ready_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_div(32'd10, 32'd4, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            run_div(ra, rb, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
